// File: rtl/huffman_bit_packer.sv
// huffman_bit_packer
// Packs Huffman codewords for a stream of gray symbols (1..6) into an
// MSB-first byte stream with valid/ready handshakes on both sides.
//
// Ports:
//   clk, reset          clock (rising edge), synchronous active-high reset
//   code_valid          codeword tables valid (level); latched once in IDLE
//   HC1..HC6, M1..M6    right-aligned codewords and their length masks
//   sym_valid/sym_data/sym_last/sym_ready   symbol input handshake
//   byte_valid/byte_data/byte_last/byte_ready   packed byte output handshake
//   bit_total           total code bits accepted, saturating at 0xFFFF
//   err                 sticky: illegal symbol consumed
//   done                sticky: final byte transferred (or empty stream ended)
module huffman_bit_packer #(
    parameter int ACC_W = 16,
    parameter int NSYM  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [7:0]        HC1,
    input  logic [7:0]        HC2,
    input  logic [7:0]        HC3,
    input  logic [7:0]        HC4,
    input  logic [7:0]        HC5,
    input  logic [7:0]        HC6,
    input  logic [7:0]        M1,
    input  logic [7:0]        M2,
    input  logic [7:0]        M3,
    input  logic [7:0]        M4,
    input  logic [7:0]        M5,
    input  logic [7:0]        M6,
    input  logic              sym_valid,
    input  logic [7:0]        sym_data,
    input  logic              sym_last,
    output logic              sym_ready,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_last,
    input  logic              byte_ready,
    output logic [15:0]       bit_total,
    output logic              err,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) begin
            c = c + {3'd0, v[i]};
        end
        return c;
    endfunction

    state_t             r_state;
    state_t             w_state_nx;
    logic [ACC_W-1:0]   r_acc;
    logic [4:0]         r_cnt;
    logic [15:0]        r_bit_total;
    logic               r_err;
    logic [7:0]         r_hc  [NSYM];
    logic [3:0]         r_len [NSYM];

    logic [7:0]         w_hc_in [NSYM];
    logic [7:0]         w_m_in  [NSYM];
    logic               w_sym_legal;
    logic [7:0]         w_code;
    logic [3:0]         w_len;
    logic [7:0]         w_code_m;
    logic               w_accept;
    logic               w_xfer;
    logic               w_app;
    logic [ACC_W-1:0]   w_acc_sh;
    logic [4:0]         w_cnt_sh;
    logic [4:0]         w_shamt;
    logic [ACC_W-1:0]   w_ins;
    logic [ACC_W-1:0]   w_acc_nx;
    logic [4:0]         w_cnt_nx;
    logic [16:0]        w_total_sum;
    logic [15:0]        w_total_nx;

    assign w_hc_in[0] = HC1;
    assign w_hc_in[1] = HC2;
    assign w_hc_in[2] = HC3;
    assign w_hc_in[3] = HC4;
    assign w_hc_in[4] = HC5;
    assign w_hc_in[5] = HC6;
    assign w_m_in[0]  = M1;
    assign w_m_in[1]  = M2;
    assign w_m_in[2]  = M3;
    assign w_m_in[3]  = M4;
    assign w_m_in[4]  = M5;
    assign w_m_in[5]  = M6;

    // Codeword lookup for the offered symbol; out-of-range symbols select nothing.
    always_comb begin
        w_sym_legal = 1'b0;
        w_code      = 8'd0;
        w_len       = 4'd0;
        case (sym_data)
            8'd1:    begin w_sym_legal = 1'b1; w_code = r_hc[0]; w_len = r_len[0]; end
            8'd2:    begin w_sym_legal = 1'b1; w_code = r_hc[1]; w_len = r_len[1]; end
            8'd3:    begin w_sym_legal = 1'b1; w_code = r_hc[2]; w_len = r_len[2]; end
            8'd4:    begin w_sym_legal = 1'b1; w_code = r_hc[3]; w_len = r_len[3]; end
            8'd5:    begin w_sym_legal = 1'b1; w_code = r_hc[4]; w_len = r_len[4]; end
            8'd6:    begin w_sym_legal = 1'b1; w_code = r_hc[5]; w_len = r_len[5]; end
            default: begin w_sym_legal = 1'b0; w_code = 8'd0;    w_len = 4'd0;     end
        endcase
    end

    // Accumulator update: shift out a transferred byte first, then append the
    // new code at the post-shift fill position. Bits below the fill level are
    // always zero, which gives the zero pad of the last byte for free.
    always_comb begin
        w_accept = sym_valid & sym_ready;
        w_xfer   = byte_valid & byte_ready;
        w_app    = w_accept & w_sym_legal;
        w_code_m = w_code & (8'hFF >> (4'd8 - w_len));
        if (w_xfer) begin
            w_acc_sh = {r_acc[ACC_W-9:0], 8'd0};
            w_cnt_sh = (r_cnt > 5'd8) ? (r_cnt - 5'd8) : 5'd0;
        end else begin
            w_acc_sh = r_acc;
            w_cnt_sh = r_cnt;
        end
        // Accept needs cnt <= 8 and len <= 8, so the shift amount never underflows.
        w_shamt     = 5'd16 - w_cnt_sh - {1'b0, w_len};
        w_ins       = {8'd0, w_code_m} << w_shamt;
        w_total_sum = {1'b0, r_bit_total} + {13'd0, w_len};
        if (w_app) begin
            w_acc_nx   = w_acc_sh | w_ins;
            w_cnt_nx   = w_cnt_sh + {1'b0, w_len};
            w_total_nx = w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end else begin
            w_acc_nx   = w_acc_sh;
            w_cnt_nx   = w_cnt_sh;
            w_total_nx = r_bit_total;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // FSM next-state decode.
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (code_valid) begin
                    w_state_nx = S_RUN;
                end else begin
                    w_state_nx = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_accept && sym_last) begin
                    // An illegal final symbol on an empty accumulator leaves nothing to flush.
                    w_state_nx = (w_cnt_nx == 5'd0) ? S_DONE : S_FLUSH;
                end else begin
                    w_state_nx = S_RUN;
                end
            end
            S_FLUSH: begin
                if (w_xfer && byte_last) begin
                    w_state_nx = S_DONE;
                end else begin
                    w_state_nx = S_FLUSH;
                end
            end
            S_DONE:  w_state_nx = S_DONE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // FSM outputs, decoded from registers only.
    always_comb begin
        sym_ready  = (r_state == S_RUN) && (r_cnt <= 5'd8);
        byte_valid = (((r_state == S_RUN) || (r_state == S_FLUSH)) && (r_cnt >= 5'd8)) ||
                     ((r_state == S_FLUSH) && (r_cnt > 5'd0));
        byte_data  = r_acc[ACC_W-1:ACC_W-8];
        byte_last  = (r_state == S_FLUSH) && (r_cnt <= 5'd8);
        done       = (r_state == S_DONE);
        bit_total  = r_bit_total;
        err        = r_err;
    end

    // Datapath registers: code tables, accumulator, counters, sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_cnt       <= 5'd0;
            r_bit_total <= 16'd0;
            r_err       <= 1'b0;
            for (int i = 0; i < NSYM; i++) begin
                r_hc[i]  <= 8'd0;
                r_len[i] <= 4'd0;
            end
        end else begin
            if ((r_state == S_IDLE) && code_valid) begin
                for (int i = 0; i < NSYM; i++) begin
                    r_hc[i]  <= w_hc_in[i];
                    r_len[i] <= popcount8(w_m_in[i]);
                end
            end
            r_acc       <= w_acc_nx;
            r_cnt       <= w_cnt_nx;
            r_bit_total <= w_total_nx;
            if (w_accept && !w_sym_legal) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_huffman_bit_packer.sv
// Bench for huffman_bit_packer: table of symbol streams with expected bytes,
// plus hand sequences for backpressure, mid-stream reset and saturation.
module tb_huffman_bit_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [7:0]  HC1, HC2, HC3, HC4, HC5, HC6;
    logic [7:0]  M1, M2, M3, M4, M5, M6;
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_last;
    logic        sym_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic [15:0] bit_total;
    logic        err;
    logic        done;

    huffman_bit_packer dut (
        .clk(clk), .reset(reset), .code_valid(code_valid),
        .HC1(HC1), .HC2(HC2), .HC3(HC3), .HC4(HC4), .HC5(HC5), .HC6(HC6),
        .M1(M1), .M2(M2), .M3(M3), .M4(M4), .M5(M5), .M6(M6),
        .sym_valid(sym_valid), .sym_data(sym_data), .sym_last(sym_last),
        .sym_ready(sym_ready), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(byte_ready), .bit_total(bit_total),
        .err(err), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]       nsym;
        logic [7:0][7:0]  syms;    // syms[0] is sent first
        logic [1:0]       nbytes;
        logic [2:0][7:0]  bytes;   // bytes[0] expected first; last one carries byte_last
        logic [15:0]      total;
        logic             err;
    } vec_t;

    vec_t        vecs [6];
    logic [8:0]  sb [$];           // {last, data}
    int          checks = 0;
    int          errors = 0;
    logic        accepted;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Called once per cycle at the falling edge: records symbol acceptance
    // and compares any byte that transfers on the coming rising edge.
    task automatic mon();
        logic [8:0] e;
        accepted = !reset && sym_valid && sym_ready;
        if (!reset && byte_valid && byte_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_byte actual=%02h required=none", byte_data);
            end else begin
                e = sb.pop_front();
                chk("byte_data", {24'd0, byte_data}, {24'd0, e[7:0]});
                chk("byte_last", {31'd0, byte_last}, {31'd0, e[8]});
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic set_codes();
        HC1 = 8'h00; M1 = 8'h01;
        HC2 = 8'h02; M2 = 8'h03;
        HC3 = 8'h06; M3 = 8'h07;
        HC4 = 8'h0E; M4 = 8'h0F;
        HC5 = 8'h1E; M5 = 8'h1F;
        HC6 = 8'h1F; M6 = 8'h1F;
    endtask

    task automatic scramble_codes();
        HC1 = 8'h55; HC2 = 8'h55; HC3 = 8'h55; HC4 = 8'h55; HC5 = 8'h55; HC6 = 8'h55;
        M1 = 8'hFF; M2 = 8'hFF; M3 = 8'hFF; M4 = 8'hFF; M5 = 8'hFF; M6 = 8'hFF;
    endtask

    task automatic do_reset();
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        reset      = 1'b1;
        cyc();
        reset      = 1'b0;
        sb.delete();
    endtask

    // Latch good tables, then disturb the inputs to show they are ignored.
    task automatic start_stream();
        set_codes();
        code_valid = 1'b1;
        cyc();
        scramble_codes();
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit ok;
        ok        = 1'b0;
        sym_valid = 1'b1;
        sym_data  = d;
        sym_last  = l;
        for (int k = 0; k < 100; k++) begin
            cyc();
            if (accepted) begin
                ok = 1'b1;
                break;
            end
        end
        sym_valid = 1'b0;
        sym_last  = 1'b0;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout actual=not_accepted required=accepted sym=%0d", d);
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            if (done) break;
            cyc();
        end
        chk("done", {31'd0, done}, 32'd1);
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_sym_ready"},  {31'd0, sym_ready},  32'd0);
        chk({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
        chk({tag, "_byte_data"},  {24'd0, byte_data},  32'd0);
        chk({tag, "_byte_last"},  {31'd0, byte_last},  32'd0);
        chk({tag, "_bit_total"},  {16'd0, bit_total},  32'd0);
        chk({tag, "_err"},        {31'd0, err},        32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
    endtask

    initial begin
        vecs[0] = '{nsym: 4'd4, syms: {8'd0, 8'd0, 8'd0, 8'd0, 8'd4, 8'd3, 8'd2, 8'd1},
                    nbytes: 2'd2, bytes: {8'h00, 8'h80, 8'h5B}, total: 16'd10, err: 1'b0};
        vecs[1] = '{nsym: 4'd4, syms: {8'd0, 8'd0, 8'd0, 8'd0, 8'd6, 8'd6, 8'd6, 8'd6},
                    nbytes: 2'd3, bytes: {8'hF0, 8'hFF, 8'hFF}, total: 16'd20, err: 1'b0};
        vecs[2] = '{nsym: 4'd8, syms: {8{8'd1}},
                    nbytes: 2'd1, bytes: {8'h00, 8'h00, 8'h00}, total: 16'd8, err: 1'b0};
        vecs[3] = '{nsym: 4'd2, syms: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd7},
                    nbytes: 2'd1, bytes: {8'h00, 8'h00, 8'h80}, total: 16'd2, err: 1'b1};
        vecs[4] = '{nsym: 4'd1, syms: {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                    nbytes: 2'd0, bytes: {8'h00, 8'h00, 8'h00}, total: 16'd0, err: 1'b1};
        vecs[5] = '{nsym: 4'd6, syms: {8'd0, 8'd0, 8'd4, 8'd1, 8'd2, 8'd6, 8'd3, 8'd5},
                    nbytes: 2'd3, bytes: {8'hE0, 8'hFC, 8'hF6}, total: 16'd20, err: 1'b0};

        reset      = 1'b1;
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        sym_data   = 8'd0;
        sym_last   = 1'b0;
        byte_ready = 1'b1;
        set_codes();
        cyc();
        cyc();
        chk_cleared("reset");

        // IDLE without code_valid: symbols must not be taken.
        reset     = 1'b0;
        sym_valid = 1'b1;
        sym_data  = 8'd1;
        cyc(); cyc(); cyc();
        chk("idle_sym_ready", {31'd0, sym_ready}, 32'd0);
        chk("idle_bit_total", {16'd0, bit_total}, 32'd0);
        sym_valid = 1'b0;

        for (int v = 0; v < 6; v++) begin
            do_reset();
            for (int b = 0; b < int'(vecs[v].nbytes); b++) begin
                sb.push_back({(b == int'(vecs[v].nbytes) - 1), vecs[v].bytes[b]});
            end
            start_stream();
            for (int s = 0; s < int'(vecs[v].nsym); s++) begin
                send(vecs[v].syms[s], (s == int'(vecs[v].nsym) - 1));
            end
            wait_done();
            chk("vec_bit_total", {16'd0, bit_total}, {16'd0, vecs[v].total});
            chk("vec_err", {31'd0, err}, {31'd0, vecs[v].err});
            chk("vec_done_no_valid", {31'd0, byte_valid}, 32'd0);
            chk("vec_sb_empty", sb.size(), 32'd0);
        end

        // Backpressure: 5,5 fill 10 bits, symbol 3 waits, byte held stable.
        do_reset();
        sb.push_back({1'b0, 8'hF7});
        sb.push_back({1'b1, 8'hB0});
        byte_ready = 1'b0;
        start_stream();
        send(8'd5, 1'b0);
        send(8'd5, 1'b0);
        sym_valid = 1'b1;
        sym_data  = 8'd3;
        sym_last  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("bp_sym_ready", {31'd0, sym_ready}, 32'd0);
            chk("bp_byte_valid", {31'd0, byte_valid}, 32'd1);
            chk("bp_byte_data", {24'd0, byte_data}, 32'h0000_00F7);
            chk("bp_byte_last", {31'd0, byte_last}, 32'd0);
            chk("bp_bit_total", {16'd0, bit_total}, 32'd10);
        end
        byte_ready = 1'b1;
        send(8'd3, 1'b1);
        wait_done();
        chk("bp_total_end", {16'd0, bit_total}, 32'd13);
        chk("bp_sb_empty", sb.size(), 32'd0);

        // Reset in RUN with 5 bits buffered; code_valid stays high to relatch.
        do_reset();
        start_stream();
        send(8'd5, 1'b0);
        chk("mid_bit_total", {16'd0, bit_total}, 32'd5);
        set_codes();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk_cleared("midreset");
        sb.push_back({1'b0, 8'h5B});
        sb.push_back({1'b1, 8'h80});
        send(8'd1, 1'b0);
        send(8'd2, 1'b0);
        send(8'd3, 1'b0);
        send(8'd4, 1'b1);
        wait_done();
        chk("restart_total", {16'd0, bit_total}, 32'd10);
        chk("restart_err", {31'd0, err}, 32'd0);
        chk("restart_sb_empty", sb.size(), 32'd0);

        // Saturation: 13108 x symbol 6 = 65540 bits -> 8192 x FF then F0.
        do_reset();
        for (int b = 0; b < 8192; b++) sb.push_back({1'b0, 8'hFF});
        sb.push_back({1'b1, 8'hF0});
        start_stream();
        for (int s = 0; s < 13108; s++) begin
            send(8'd6, (s == 13107));
        end
        wait_done();
        chk("sat_bit_total", {16'd0, bit_total}, 32'h0000_FFFF);
        chk("sat_sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/huffman_bit_packer.md
Name: huffman_bit_packer

Overview:
- Downstream consumer of the Huffman code generator.
- Latches the six codewords (HCn value, Mn length mask) when code_valid rises.
- Encodes a stream of gray symbols (values 1..6) into an MSB-first packed byte stream, with byte-level valid/ready backpressure.
- Terminates with zero-padding of the final partial byte, a byte_last marker, and a sticky done.

Parameters:
- ACC_W, 16, bit accumulator width; fixed at 2*8. Must not be changed.
- NSYM, 6, number of symbols/codewords; fixed.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- code_valid  input  1  codeword tables valid; level, held high by producer.
- HC1..HC6  input  8 each  codeword n, right-aligned.
- M1..M6  input  8 each  length mask n; code length = popcount(Mn), 1..8.
- sym_valid  input  1  symbol offered.
- sym_data  input  8  symbol value; legal 1..6.
- sym_last  input  1  qualifies the final symbol of the stream.
- sym_ready  output  1  packer accepts a symbol this cycle.
- byte_valid  output  1  byte_data valid.
- byte_data  output  8  packed byte; first code bit in bit 7.
- byte_last  output  1  final byte of the stream (qualified by byte_valid).
- byte_ready  input  1  downstream accepts byte.
- bit_total  output  16  total code bits accepted; saturates at 0xFFFF.
- err  output  1  sticky: illegal symbol seen.
- done  output  1  sticky: final byte transferred.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; accumulator, cnt, bit_total, err, done all 0; sym_ready=0; byte_valid=0; byte_last=0; byte_data=0. Reset mid-stream discards all buffered bits and tables.
- IDLE: on the first cycle code_valid=1, latch HC1..6 and len1..6=popcount(M1..6), then go to RUN. Changes to code inputs after latching are ignored until the next reset.
- Accumulator acc[15:0] is left-aligned; cnt (0..16) is the number of valid bits, which occupy acc[15:16-cnt].
- RUN:
  - sym_ready = (cnt <= 8).
  - Accept on sym_valid & sym_ready.
  - Legal symbol s: append HCs[len-1:0] MSB-first at acc[15-cnt]; cnt += len; bit_total += len (saturating).
  - Illegal symbol (0 or >6): consumed, no bits appended, err set.
  - sym_last on an accepted beat: go to FLUSH, regardless of symbol legality.
- Byte output:
  - byte_valid = (cnt >= 8) in RUN or FLUSH, or (cnt > 0) in FLUSH.
  - byte_data = acc[15:8]; unused low bits are 0 (zero pad).
  - byte_last = FLUSH & (cnt <= 8).
  - Transfer on byte_valid & byte_ready: acc <<= 8; cnt = max(cnt-8, 0).
- Simultaneous accept and transfer in one cycle: shift first, then append at the post-shift position; cnt_next = cnt - 8 + len.
- Latency: a symbol accepted at edge N that completes a byte shows byte_valid=1 after edge N. All outputs are registered or decoded from registers; there is no combinational path from inputs to outputs.
- Output stability: byte_data and byte_last hold stable while byte_valid=1 and byte_ready=0.
- FLUSH: sym_ready=0. When the byte_last byte transfers, go to DONE.
  - Legal last symbol: FLUSH is entered with cnt > 0.
  - Illegal last symbol with cnt=0: go directly to DONE, no byte emitted.
- DONE: done=1, sym_ready=0, byte_valid=0. Stays until reset. code_valid is ignored.
- Symbols offered in IDLE are not accepted (sym_ready=0).

Test Plan:
Codes used in all tests: HC/M = 1:00/01 "0", 2:02/03 "10", 3:06/07 "110", 4:0E/0F "1110", 5:1E/1F "11110", 6:1F/1F "11111". byte_ready=1 unless noted.
- Symbols 1,2,3,4 (sym_last on 4) -> bytes 0x5B, then 0x80 with byte_last=1; bit_total=10; done=1 after transfer.
- Symbols 6,6,6,6 (last) -> 0xFF, 0xFF, 0xF0 (byte_last=1); bit_total=20.
- Eight symbol 1 (last on 8th) -> exactly one byte 0x00 with byte_last=1; no pad byte follows.
- byte_ready=0, symbols 5,5,3 offered -> 5 and 5 accepted (cnt=10); sym_ready=0 and symbol 3 held; byte_data=0xF7 held stable. Raise byte_ready -> 0xF7 transfers, 3 is accepted, cnt=5.
- Symbol 7 then symbol 2 (last) -> err=1; only "10" encoded; single byte 0x80 with byte_last=1.
- Reset asserted in RUN with cnt=5 -> next cycle all outputs 0 and state IDLE; with code_valid high the next cycle, tables relatch and the stream restarts cleanly.
